// File: rtl/led_seq_pkg.sv
// Shared mode encoding and per-mode initial LED patterns for led_sequencer.
// Pattern bit 0 drives D1, bit 3 drives D4.
package led_seq_pkg;

    localparam int unsigned ModeWidth = 2;

    typedef enum logic [ModeWidth-1:0] {
        ModeOff    = 2'd0,
        ModeChase  = 2'd1,
        ModeBounce = 2'd2,
        ModeBlink  = 2'd3
    } mode_e;

    localparam logic [3:0] PatOff    = 4'b0000;
    localparam logic [3:0] PatChase  = 4'b0001;
    localparam logic [3:0] PatBounce = 4'b0001;
    localparam logic [3:0] PatBlink  = 4'b1111;

    function automatic logic [3:0] init_pattern(input mode_e mode);
        logic [3:0] pat;
        case (mode)
            ModeChase:  pat = PatChase;
            ModeBounce: pat = PatBounce;
            ModeBlink:  pat = PatBlink;
            default:    pat = PatOff;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus level debouncer for a raw push-button.
// press pulses for one cycle, in the first cycle the debounced level reads 1.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q;

    // Counter tracks consecutive cycles the synchronized input disagrees with level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= BTN;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Button-driven four-LED pattern sequencer (OFF, CHASE, BOUNCE, BLINK) with status LED D5.
// Define LED_SEQUENCER_HEARTBEAT_EN to make D5 a heartbeat toggling every 4 ticks.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 12000000,
    parameter int unsigned STEP_HZ         = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BTN,
    output logic                 D1,
    output logic                 D2,
    output logic                 D3,
    output logic                 D4,
    output logic                 D5,
    output logic [ModeWidth-1:0] MODE
);

    localparam int unsigned Div   = CLK_HZ / STEP_HZ;
    localparam int unsigned PresW = $clog2(Div);

    logic             press;
    logic             btn_level;
    logic             unused_btn_level;
    logic             tick;
    logic             up;
    logic [PresW-1:0] presc_q, presc_d;
    mode_e            mode_q, mode_d;
    logic [3:0]       pat_q, pat_d;
    logic             dir_up_q, dir_up_d;
    logic             d5_q, d5_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN),
        .level(btn_level),
        .press(press)
    );

    assign unused_btn_level = btn_level;
    assign tick             = (presc_q == PresW'(Div - 1));

    always_comb begin
        presc_d  = presc_q;
        mode_d   = mode_q;
        pat_d    = pat_q;
        dir_up_d = dir_up_q;
        up       = 1'b0;
        if (press) begin
            // A press outranks a coincident tick; that tick is dropped.
            mode_d   = mode_e'(ModeWidth'(mode_q + 2'd1));
            pat_d    = init_pattern(mode_d);
            dir_up_d = 1'b1;
            presc_d  = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                case (mode_q)
                    ModeChase: pat_d = {pat_q[2:0], pat_q[3]};
                    ModeBounce: begin
                        // Turn around at either end, otherwise keep the current direction.
                        up       = (dir_up_q && !pat_q[3]) || pat_q[0];
                        pat_d    = up ? (pat_q << 1) : (pat_q >> 1);
                        dir_up_d = up;
                    end
                    ModeBlink: pat_d = ~pat_q;
                    default:   pat_d = pat_q;
                endcase
            end
        end
    end

`ifdef LED_SEQUENCER_HEARTBEAT_EN
    logic [1:0] hb_q, hb_d;

    always_comb begin
        hb_d = hb_q;
        d5_d = d5_q;
        if (tick && !press) begin
            hb_d = hb_q + 2'd1;
            if (hb_q == 2'd3) begin
                d5_d = ~d5_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hb_q <= 2'd0;
        end else begin
            hb_q <= hb_d;
        end
    end
`else
    // Registered from next-state so D5 changes in the same cycle as MODE.
    assign d5_d = (mode_d != ModeOff);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q  <= '0;
            mode_q   <= ModeOff;
            pat_q    <= 4'b0000;
            dir_up_q <= 1'b0;
            d5_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            pat_q    <= pat_d;
            dir_up_q <= dir_up_d;
            d5_q     <= d5_d;
        end
    end

    assign D1   = pat_q[0];
    assign D2   = pat_q[1];
    assign D3   = pat_q[2];
    assign D4   = pat_q[3];
    assign D5   = d5_q;
    assign MODE = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer: tick every 8 cycles, 4-cycle debounce.
// Builds with or without LED_SEQUENCER_HEARTBEAT_EN.
module tb_led_sequencer;

    logic       CLK;
    logic       RST_N;
    logic       BTN;
    logic       D1, D2, D3, D4, D5;
    logic [1:0] MODE;
    logic [3:0] leds;

    int n_checks;
    int n_fail;

    led_sequencer #(
        .CLK_HZ         (16),
        .STEP_HZ        (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN),
        .D1   (D1),
        .D2   (D2),
        .D3   (D3),
        .D4   (D4),
        .D5   (D5),
        .MODE (MODE)
    );

    assign leds = {D1, D2, D3, D4};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic adv(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Mode changes 7 cycles after BTN rises: 2 sync, 4 debounce, 1 press-to-mode.
    task automatic press(input logic [1:0] exp_mode, input logic [3:0] exp_leds);
        BTN = 1'b1;
        adv(7);
        BTN = 1'b0;
        check("press_mode", {6'd0, MODE}, {6'd0, exp_mode});
        check("press_leds", {4'd0, leds}, {4'd0, exp_leds});
`ifndef LED_SEQUENCER_HEARTBEAT_EN
        check("press_d5", {7'd0, D5}, {7'd0, (exp_mode != 2'd0)});
`endif
    endtask

    logic [3:0] bounce_exp [6];
    logic       prev_d5;
    logic       found;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST_N    = 1'b0;
        BTN      = 1'b0;
        bounce_exp = '{4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            BTN = ~BTN;
            check("rst_mode", {6'd0, MODE}, 8'd0);
            check("rst_leds", {3'd0, leds, D5}, 8'd0);
        end
        @(negedge CLK);
        BTN   = 1'b0;
        RST_N = 1'b1;
        adv(12);
        check("post_rst_mode", {6'd0, MODE}, 8'd0);
        check("post_rst_leds", {3'd0, leds, D5}, 8'd0);

        // Too-short pulse is rejected.
        BTN = 1'b1;
        adv(3);
        BTN = 1'b0;
        adv(10);
        check("glitch_mode", {6'd0, MODE}, 8'd0);

        // Button held 20 cycles: single press into CHASE.
        BTN = 1'b1;
        adv(6);
        check("pre_press_mode", {6'd0, MODE}, 8'd0);
        adv(1);
        check("chase_mode", {6'd0, MODE}, 8'd1);
        check("chase0", {4'd0, leds}, 8'b1000);
`ifndef LED_SEQUENCER_HEARTBEAT_EN
        check("chase_d5", {7'd0, D5}, 8'd1);
`endif
        adv(7);
        check("chase0_hold", {4'd0, leds}, 8'b1000);
        adv(1);
        check("chase1", {4'd0, leds}, 8'b0100);
        adv(5);
        check("held_mode", {6'd0, MODE}, 8'd1);
        BTN = 1'b0;
        adv(7);
        check("chase2", {4'd0, leds}, 8'b0010);
        adv(8);
        check("chase3", {4'd0, leds}, 8'b0001);
        adv(8);
        check("chase4", {4'd0, leds}, 8'b1000);
        adv(8);
        check("chase5", {4'd0, leds}, 8'b0100);
        check("once_mode", {6'd0, MODE}, 8'd1);

        // BOUNCE, prescaler restarted at the press.
        press(2'd2, 4'b1000);
        adv(7);
        check("bounce0_hold", {4'd0, leds}, 8'b1000);
        adv(1);
        check("bounce1", {4'd0, leds}, 8'b0100);
        for (int i = 0; i < 6; i++) begin
            adv(8);
            check("bounce_seq", {4'd0, leds}, {4'd0, bounce_exp[i]});
        end

        press(2'd3, 4'b1111);
        adv(8);
        check("blink1", {4'd0, leds}, 8'b0000);
        press(2'd0, 4'b0000);
        adv(8);
        check("off_tick", {4'd0, leds}, 8'b0000);

        // Presses whose pulse lands on a tick cycle.
        adv(1);
        press(2'd1, 4'b1000);
        adv(7);
        check("coll1_hold", {4'd0, leds}, 8'b1000);
        adv(1);
        check("coll1_step", {4'd0, leds}, 8'b0100);
        adv(1);
        press(2'd2, 4'b1000);
        adv(7);
        check("coll2_hold", {4'd0, leds}, 8'b1000);
        adv(1);
        check("coll2_step", {4'd0, leds}, 8'b0100);

`ifdef LED_SEQUENCER_HEARTBEAT_EN
        press(2'd3, 4'b1111);
        press(2'd0, 4'b0000);
        prev_d5 = D5;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            adv(1);
            if (D5 !== prev_d5) found = 1'b1;
        end
        check("hb_seen", {7'd0, found}, 8'd1);
        prev_d5 = D5;
        adv(31);
        check("hb_hold", {7'd0, D5}, {7'd0, prev_d5});
        adv(1);
        check("hb_toggle", {7'd0, D5}, {7'd0, ~prev_d5});
        check("hb_mode", {6'd0, MODE}, 8'd0);
`endif

        // Reset mid-pattern and mid-debounce.
        adv(3);
        BTN = 1'b1;
        adv(4);
        RST_N = 1'b0;
        #1;
        check("abort_mode", {6'd0, MODE}, 8'd0);
        check("abort_leds", {3'd0, leds, D5}, 8'd0);
        @(negedge CLK);
        BTN = 1'b0;
        adv(1);
        RST_N = 1'b1;
        adv(12);
        check("abort_post_mode", {6'd0, MODE}, 8'd0);
        check("abort_post_leds", {3'd0, leds, D5}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 8, pattern step rate in Hz; CLK_HZ/STEP_HZ SHALL be at least 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 120000, number of stable cycles required to accept a button level.
REQ-004 CLK  input  1  single system clock; all state on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 BTN  input  1  raw push-button, active-high, asynchronous to CLK.
REQ-007 D1, D2, D3, D4  output  1 each  pattern LEDs, active-high.
REQ-008 D5  output  1  status LED, active-high.
REQ-009 MODE  output  2  current mode: 0 OFF, 1 CHASE, 2 BOUNCE, 3 BLINK.

Function
REQ-010 BTN SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-011 A press SHALL be a 0->1 transition of the debounced level, producing a 1-cycle press pulse.
REQ-012 The prescaler SHALL count 0..CLK_HZ/STEP_HZ-1 and wrap to 0; tick SHALL be a 1-cycle pulse on the wrap cycle.
REQ-013 Each press SHALL advance MODE by 1, wrapping 3->0, visible on MODE the cycle after the pulse.
REQ-014 On a mode change, the pattern state SHALL load the new mode's initial value and the prescaler SHALL restart at 0.
REQ-015 If press and tick coincide, the press SHALL take priority; that tick SHALL be discarded.
REQ-016 OFF: D1-D4 = 0000; ticks ignored.
REQ-017 CHASE: initial D1 only lit; each tick rotates one-hot D1->D2->D3->D4->D1.
REQ-018 BOUNCE: initial D1 lit, direction up; each tick moves one position; direction reverses at D4 and D1, giving the 6-tick sequence D1,D2,D3,D4,D3,D2.
REQ-019 BLINK: initial D1-D4 = 1111; each tick inverts all four.
REQ-020 LED outputs SHALL be registered; a pattern update becomes visible the cycle after its tick.
REQ-021 Press detection SHALL be independent of mode; a held button SHALL produce exactly one press.

Reset
REQ-022 While RST_N=0: MODE=0, D1-D5=0, prescaler=0, debounced level=0, synchronizer=0, debounce counter=0, pattern state=0.
REQ-023 Reset assertion mid-pattern or mid-debounce SHALL abort immediately; after release, operation SHALL restart from OFF with no spurious press.

Configuration
REQ-024 With macro LED_SEQUENCER_HEARTBEAT_EN defined, D5 SHALL toggle every 4 ticks in all modes, including OFF.
REQ-025 Without LED_SEQUENCER_HEARTBEAT_EN, D5 SHALL equal (MODE != 0), registered, and the heartbeat counter SHALL not exist.

Structure
REQ-026 A shared package led_seq_pkg SHALL hold the mode enumeration (OFF, CHASE, BOUNCE, BLINK), the 2-bit mode width, and the initial-pattern constants per mode.
REQ-027 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, with parameter DEBOUNCE_CYCLES and outputs level and press.

Verification (bench uses CLK_HZ=16, STEP_HZ=2, giving a tick every 8 cycles, and DEBOUNCE_CYCLES=4)
REQ-028 Reset: hold RST_N low for 3 cycles with BTN toggling -> MODE=0 and D1-D5=0 throughout, with no press after release.
REQ-029 Debounce: BTN high for 3 cycles then low -> MODE stays 0. BTN held high for 20 cycles -> MODE=1 exactly once, with D1-D4=1000.
REQ-030 CHASE: in MODE=1, wait 5 ticks (40 cycles) -> D1-D4 sequence 1000,0100,0010,0001,1000,0100.
REQ-031 BOUNCE and wrap: press to MODE=2 and run 7 ticks -> D1,D2,D3,D4,D3,D2,D1,D2. Two further presses -> MODE=3 (D1-D4 = 1111, then 0000 after the next tick), then MODE=0.
REQ-032 Collision: press pulse lands on a tick cycle -> the new mode's initial pattern is shown and the next update occurs 8 cycles later.
REQ-033 D5: with the macro defined, D5 toggles every 32 cycles in MODE=0. With the macro undefined, D5=1 exactly when MODE!=0.
